mul_share_ctrl: RTL and testbench

Arbiter and sequencer that shares one pipelined 8x8 multiplier (`vedic8x8`) among `NREQ` requesters. It accepts operand pairs through per-requester valid/ready handshakes and grants them round-robin. Each accepted operation issues into the multiplier with a registered `dov8` strobe, and the requester ID is tracked in an in-order tag FIFO. Each multiplier `done` pulse is returned as a one-cycle response to the requester that owns it.

---
 rtl/mul_share_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mul_share_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one pipelined 8x8 multiplier among NREQ requesters.
// Requests are granted round-robin. Each accepted operation is issued with a
// one-cycle mul_dov strobe, and its requester ID is pushed into an in-order
// tag FIFO. Every mul_done pops one tag and returns the product as a one-cycle
// response to the requester that owns that tag.
module mul_share_ctrl #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*8-1:0]    req_a,
    input  logic [NREQ*8-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    output logic                 mul_dov,
    input  logic [15:0]          mul_result,
    input  logic                 mul_done,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_result,
    output logic [CW-1:0]        inflight,
    output logic                 busy,
    output logic                 err_stray
);

    localparam int GW = $clog2(NREQ);
    localparam int PW = $clog2(DEPTH);

    // Isolates the lowest set bit (two's-complement trick).
    function automatic logic [NREQ-1:0] pick_lowest(input logic [NREQ-1:0] v);
        return v & (~v + NREQ'(1));
    endfunction

    // Converts a one-hot (or all-zero) vector to a binary index.
    function automatic logic [GW-1:0] encode_oh(input logic [NREQ-1:0] oh);
        logic [GW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = idx | (oh[i] ? GW'(i) : GW'(0));
        end
        return idx;
    endfunction

    // Converts a binary requester index to a one-hot vector.
    function automatic logic [NREQ-1:0] decode_oh(input logic [GW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

    // Registered state
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [7:0]      mul_a_q, mul_a_d;
    logic [7:0]      mul_b_q, mul_b_d;
    logic            mul_dov_q, mul_dov_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic            busy_q, busy_d;
    logic            err_stray_q, err_stray_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [GW-1:0]   tag_mem_q [DEPTH];
    logic [GW-1:0]   tag_mem_d [DEPTH];

    // Arbitration and datapath helpers
    logic            full_s;
    logic [NREQ-1:0] mask_hi_s;
    logic [NREQ-1:0] cand_hi_s;
    logic [NREQ-1:0] grant_s;
    logic [GW-1:0]   grant_idx_s;
    logic            accept_s;
    logic            pop_s;
    logic            stray_s;
    logic [7:0]      sel_a_s;
    logic [7:0]      sel_b_s;

    // Round-robin grant: prefer requesters above last_grant, else wrap to the lowest.
    always_comb begin
        full_s    = (inflight_q == CW'(DEPTH));
        mask_hi_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            mask_hi_s[i] = (i > int'(last_grant_q));
        end
        cand_hi_s = req_valid & mask_hi_s;
        if (!reset || full_s) begin
            grant_s = '0;
        end else if (cand_hi_s != '0) begin
            grant_s = pick_lowest(cand_hi_s);
        end else begin
            grant_s = pick_lowest(req_valid);
        end
        grant_idx_s = encode_oh(grant_s);
        accept_s    = (grant_s != '0);
        sel_a_s     = req_a[int'(grant_idx_s) * 8 +: 8];
        sel_b_s     = req_b[int'(grant_idx_s) * 8 +: 8];
    end

    // Next-state: issue, tag FIFO push/pop, in-flight count and responses.
    always_comb begin
        pop_s   = mul_done && (inflight_q != '0);
        stray_s = mul_done && (inflight_q == '0);

        mul_dov_d    = accept_s;
        mul_a_d      = accept_s ? sel_a_s : mul_a_q;
        mul_b_d      = accept_s ? sel_b_s : mul_b_q;
        last_grant_d = accept_s ? grant_idx_s : last_grant_q;

        for (int i = 0; i < DEPTH; i++) begin
            tag_mem_d[i] = tag_mem_q[i];
        end
        if (accept_s) begin
            tag_mem_d[wr_ptr_q] = grant_idx_s;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            rsp_valid_d  = decode_oh(tag_mem_q[rd_ptr_q]);
            rsp_result_d = mul_result;
        end else begin
            rd_ptr_d     = rd_ptr_q;
            rsp_valid_d  = '0;
            rsp_result_d = rsp_result_q;
        end

        case ({accept_s, pop_s})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        busy_d      = (inflight_d != '0) || mul_dov_d;
        err_stray_d = err_stray_q || stray_s;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= GW'(NREQ - 1);
            mul_a_q      <= 8'h00;
            mul_b_q      <= 8'h00;
            mul_dov_q    <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_result_q <= 16'h0000;
            inflight_q   <= '0;
            busy_q       <= 1'b0;
            err_stray_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_dov_q    <= mul_dov_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            inflight_q   <= inflight_d;
            busy_q       <= busy_d;
            err_stray_q  <= err_stray_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i] <= tag_mem_d[i];
            end
        end
    end

    assign req_ready  = grant_s;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_dov    = mul_dov_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign inflight   = inflight_q;
    assign busy       = busy_q;
    assign err_stray  = err_stray_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Testbench for mul_share_ctrl: a behavioural multiplier with controllable
// done-withholding, a queue-based arbiter/FIFO reference model, and a
// scoreboard drained by an independent response monitor.
module tb_mul_share_ctrl;

    localparam int NREQ  = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int L     = 3;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*8-1:0]    req_a;
    logic [NREQ*8-1:0]    req_b;
    logic [NREQ-1:0]      req_ready;
    logic [7:0]           mul_a;
    logic [7:0]           mul_b;
    logic                 mul_dov;
    logic [15:0]          mul_result;
    logic                 mul_done;
    logic [NREQ-1:0]      rsp_valid;
    logic [15:0]          rsp_result;
    logic [CW-1:0]        inflight;
    logic                 busy;
    logic                 err_stray;

    mul_share_ctrl #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_dov    (mul_dov),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .inflight   (inflight),
        .busy       (busy),
        .err_stray  (err_stray)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { int id; logic [15:0] p; } rsp_t;
    typedef struct { int due; logic [15:0] p; } mop_t;

    rsp_t sb[$];      // expected responses, in issue order
    mop_t mpipe[$];   // products inside the behavioural multiplier

    int       checks;
    int       errors;
    int       cyc;
    int       last_g;
    int       infl_m;
    bit       stray_m;
    bit       prev_acc;
    logic [7:0] exp_a;
    logic [7:0] exp_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        mpipe.delete();
        last_g   = NREQ - 1;
        infl_m   = 0;
        stray_m  = 1'b0;
        prev_acc = 1'b0;
        exp_a    = 8'h00;
        exp_b    = 8'h00;
    endtask

    // One clock cycle: check registered state, run the multiplier model,
    // drive requests, check the grant and update the reference model.
    task automatic do_cycle(input logic [NREQ-1:0] v, input logic [NREQ*8-1:0] a,
                            input logic [NREQ*8-1:0] b, input bit hold, input bit stray);
        int g;
        logic [NREQ-1:0] expg;
        rsp_t r;
        mop_t m;
        @(negedge clk);
        chk("inflight", 32'(inflight), 32'(infl_m));
        chk("mul_dov", 32'(mul_dov), 32'(prev_acc));
        chk("mul_a", 32'(mul_a), 32'(exp_a));
        chk("mul_b", 32'(mul_b), 32'(exp_b));
        chk("err_stray", 32'(err_stray), 32'(stray_m));
        chk("busy", 32'(busy), 32'((infl_m != 0) || prev_acc));
        if (mul_dov) begin
            m.due = cyc + L;
            m.p   = 16'(mul_a) * 16'(mul_b);
            mpipe.push_back(m);
        end
        req_valid  = v;
        req_a      = a;
        req_b      = b;
        mul_done   = 1'b0;
        mul_result = 16'h0000;
        if (stray) begin
            mul_done   = 1'b1;
            mul_result = 16'($urandom);
        end else if (!hold && mpipe.size() > 0 && mpipe[0].due <= cyc) begin
            m          = mpipe.pop_front();
            mul_done   = 1'b1;
            mul_result = m.p;
        end
        #1;
        g = -1;
        if (infl_m < DEPTH) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (last_g + k) % NREQ;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        expg = (g >= 0) ? (NREQ'(1) << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(expg));
        if (mul_done) begin
            if (infl_m > 0) infl_m--;
            else stray_m = 1'b1;
        end
        if (g >= 0) begin
            r.id  = g;
            r.p   = 16'(a[8*g +: 8]) * 16'(b[8*g +: 8]);
            sb.push_back(r);
            last_g = g;
            exp_a  = a[8*g +: 8];
            exp_b  = b[8*g +: 8];
            infl_m++;
        end
        prev_acc = (g >= 0);
        cyc++;
    endtask

    task automatic idle_cycle();
        do_cycle('0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((infl_m > 0 || mpipe.size() > 0 || sb.size() > 0) && n < 200) begin
            idle_cycle();
            n++;
        end
        chk("drain_bound", 32'(n < 200), 32'd1);
        idle_cycle();
    endtask

    // Asserts reset for two cycles, checking reset values immediately.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '1;
        mul_done  = 1'b0;
        #1;
        chk("rst_mul_a", 32'(mul_a), 32'h0);
        chk("rst_mul_b", 32'(mul_b), 32'h0);
        chk("rst_mul_dov", 32'(mul_dov), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_result", 32'(rsp_result), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err_stray", 32'(err_stray), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        model_clear();
        @(negedge clk);
        chk("rst_req_ready_hold", 32'(req_ready), 32'h0);
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b1;
    endtask

    // Response monitor: every rsp_valid pulse must match the scoreboard head.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            #3;
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual=%b expected=none cycle=%0d", rsp_valid, cyc);
                end else begin
                    r = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << r.id));
                    chk("rsp_result", 32'(rsp_result), 32'(r.p));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ*8-1:0] a;
        logic [NREQ*8-1:0] b;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        reset      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        mul_done   = 1'b0;
        mul_result = 16'h0000;
        model_clear();
        do_reset();

        // Single request from requester 2: FF x FF.
        a = '0;
        b = '0;
        a[23:16] = 8'hFF;
        b[23:16] = 8'hFF;
        do_cycle(4'b0100, a, b, 1'b0, 1'b0);
        drain();
        chk("single_inflight_zero", 32'(inflight), 32'h0);

        // Round-robin: all valid, operands (i+3)x(i+5).
        for (int i = 0; i < NREQ; i++) begin
            a[8*i +: 8] = 8'(i + 3);
            b[8*i +: 8] = 8'(i + 5);
        end
        for (int c = 0; c < 8; c++) do_cycle('1, a, b, 1'b0, 1'b0);
        drain();

        // Full: withhold done, then release a single done.
        for (int c = 0; c < 12; c++) do_cycle('1, 32'($urandom), 32'($urandom), 1'b1, 1'b0);
        chk("full_inflight", 32'(inflight), 32'(DEPTH));
        chk("full_req_ready", 32'(req_ready), 32'h0);
        do_cycle('1, 32'($urandom), 32'($urandom), 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) do_cycle('1, 32'($urandom), 32'($urandom), 1'b1, 1'b0);
        drain();

        // Sustained simultaneous push and pop.
        for (int c = 0; c < 36; c++) do_cycle('1, 32'($urandom), 32'($urandom), 1'b0, 1'b0);
        drain();

        // Stray done with nothing in flight; flag must stay set.
        do_cycle('0, '0, '0, 1'b0, 1'b1);
        idle_cycle();
        chk("stray_flag", 32'(err_stray), 32'h1);

        // Random mix of requests and withheld dones.
        for (int c = 0; c < 150; c++) begin
            do_cycle(NREQ'($urandom), 32'($urandom), 32'($urandom),
                     ($urandom_range(3) == 0), 1'b0);
        end
        drain();

        // Reset with five operations in flight.
        for (int c = 0; c < 5; c++) do_cycle('1, 32'($urandom), 32'($urandom), 1'b1, 1'b0);
        chk("pre_reset_inflight", 32'(infl_m), 32'd5);
        do_reset();
        a = '0;
        b = '0;
        a[15:8] = 8'h0C;
        b[15:8] = 8'h0D;
        do_cycle(4'b0010, a, b, 1'b0, 1'b0);
        drain();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
